// File: rtl/islemci_cok_cevrim_if.sv
// Instruction handshake and observation bundle for islemci_cok_cevrim.
interface islemci_cok_cevrim_if #(
  parameter int VERI_GENISLIGI = 32
);
  logic [31:0]               buyruk;
  logic                      buyruk_gecerli;
  logic                      buyruk_hazir;
  logic [VERI_GENISLIGI-1:0] ps;
  logic [VERI_GENISLIGI-1:0] yazmac_gozlem;
  logic                      tamamlandi;
  logic                      gecersiz_buyruk;

  modport master (
    output buyruk, buyruk_gecerli,
    input  buyruk_hazir, ps, yazmac_gozlem, tamamlandi, gecersiz_buyruk
  );
  modport slave (
    input  buyruk, buyruk_gecerli,
    output buyruk_hazir, ps, yazmac_gozlem, tamamlandi, gecersiz_buyruk
  );
endinterface

// File: rtl/islemci_cok_cevrim.sv
// Multi-cycle RV32I-subset core (BEKLE -> YURUT -> YAZ), one instruction per handshake.
// Optional ISLEMCI_CARPMA_EN adds MUL through an iterative shift-add CARP state.
module islemci_cok_cevrim #(
  parameter int                        VERI_GENISLIGI = 32,
  parameter int                        YAZMAC_SAYISI  = 32,
  parameter logic [VERI_GENISLIGI-1:0] BASLANGIC_PS   = '0,
  parameter int                        GOZLEM_YAZMACI = 10
) (
  input  logic                 saat,
  input  logic                 reset_n,
  islemci_cok_cevrim_if.slave  bus
);
  localparam int XL    = VERI_GENISLIGI;
  localparam int SH_W  = $clog2(XL);
  localparam int IDX_W = (YAZMAC_SAYISI > 1) ? $clog2(YAZMAC_SAYISI) : 1;

  typedef enum logic [1:0] {BEKLE, YURUT, YAZ, CARP} durum_t;

  durum_t                          durum_q;
  logic [XL-1:0]                   ps_q, sonuc_q, yeni_ps_q;
  logic [YAZMAC_SAYISI-1:0][XL-1:0] regs_q;
  logic [31:0]                     buyruk_q;
  logic [4:0]                      rd_q;
  logic                            hazir_q, tamam_q, gecersiz_q, yaz_q, hata_q;

  function automatic logic idx_ok(input logic [4:0] i);
    return {1'b0, i} < 6'(YAZMAC_SAYISI);
  endfunction

  logic [6:0] opk, f7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  assign opk = buyruk_q[6:0];
  assign rd  = buyruk_q[11:7];
  assign f3  = buyruk_q[14:12];
  assign rs1 = buyruk_q[19:15];
  assign rs2 = buyruk_q[24:20];
  assign f7  = buyruk_q[31:25];

  logic [XL-1:0] a, b, imm_i, imm_b, imm_j, ps_art4, jalr_t;
  assign a     = idx_ok(rs1) ? regs_q[rs1[IDX_W-1:0]] : '0;
  assign b     = idx_ok(rs2) ? regs_q[rs2[IDX_W-1:0]] : '0;
  assign imm_i = {{(XL-12){buyruk_q[31]}}, buyruk_q[31:20]};
  assign imm_b = {{(XL-13){buyruk_q[31]}}, buyruk_q[31], buyruk_q[7], buyruk_q[30:25], buyruk_q[11:8], 1'b0};
  assign imm_j = {{(XL-21){buyruk_q[31]}}, buyruk_q[31], buyruk_q[19:12], buyruk_q[20], buyruk_q[30:21], 1'b0};
  assign ps_art4 = ps_q + XL'(4);
  assign jalr_t  = a + imm_i;

  logic          gecerli_d, yaz_d, islem_ok, k1, k2, kd, carp_d;
  logic [XL-1:0] sonuc_d, yeni_ps_d;

  always_comb begin
    islem_ok  = 1'b0;
    k1 = 1'b0; k2 = 1'b0; kd = 1'b0;
    carp_d    = 1'b0;
    sonuc_d   = '0;
    yeni_ps_d = ps_art4;
    case (opk)
      7'b0110011: begin
        k1 = 1'b1; k2 = 1'b1; kd = 1'b1;
        islem_ok = 1'b1;
        case ({f7, f3})
          {7'h00, 3'd0}: sonuc_d = a + b;
          {7'h20, 3'd0}: sonuc_d = a - b;
          {7'h00, 3'd1}: sonuc_d = a << b[SH_W-1:0];
          {7'h00, 3'd2}: sonuc_d = XL'($signed(a) < $signed(b));
          {7'h00, 3'd3}: sonuc_d = XL'(a < b);
          {7'h00, 3'd4}: sonuc_d = a ^ b;
          {7'h00, 3'd5}: sonuc_d = a >> b[SH_W-1:0];
          {7'h20, 3'd5}: sonuc_d = $unsigned($signed(a) >>> b[SH_W-1:0]);
          {7'h00, 3'd6}: sonuc_d = a | b;
          {7'h00, 3'd7}: sonuc_d = a & b;
`ifdef ISLEMCI_CARPMA_EN
          {7'h01, 3'd0}: carp_d = 1'b1;
`endif
          default:       islem_ok = 1'b0;
        endcase
      end
      7'b0010011: begin
        k1 = 1'b1; kd = 1'b1;
        islem_ok = 1'b1;
        case (f3)
          3'd0: sonuc_d = a + imm_i;
          3'd2: sonuc_d = XL'($signed(a) < $signed(imm_i));
          3'd3: sonuc_d = XL'(a < imm_i);
          3'd4: sonuc_d = a ^ imm_i;
          3'd6: sonuc_d = a | imm_i;
          3'd7: sonuc_d = a & imm_i;
          3'd1: begin
            sonuc_d  = a << imm_i[SH_W-1:0];
            islem_ok = (buyruk_q[31:SH_W+20] == '0);
          end
          default: begin
            // srli/srai share f3=101; bit 30 picks arithmetic, the rest of the upper field must be clear
            sonuc_d  = buyruk_q[30] ? $unsigned($signed(a) >>> imm_i[SH_W-1:0]) : (a >> imm_i[SH_W-1:0]);
            islem_ok = !buyruk_q[31] && (buyruk_q[29:SH_W+20] == '0);
          end
        endcase
      end
      7'b1100011: begin
        k1 = 1'b1; k2 = 1'b1;
        islem_ok = 1'b1;
        case (f3)
          3'd0:    if (a == b) yeni_ps_d = ps_q + imm_b;
          3'd1:    if (a != b) yeni_ps_d = ps_q + imm_b;
          3'd4:    if ($signed(a) <  $signed(b)) yeni_ps_d = ps_q + imm_b;
          3'd5:    if ($signed(a) >= $signed(b)) yeni_ps_d = ps_q + imm_b;
          3'd6:    if (a <  b) yeni_ps_d = ps_q + imm_b;
          3'd7:    if (a >= b) yeni_ps_d = ps_q + imm_b;
          default: islem_ok = 1'b0;
        endcase
      end
      7'b1101111: begin
        kd = 1'b1;
        islem_ok  = 1'b1;
        sonuc_d   = ps_art4;
        yeni_ps_d = ps_q + imm_j;
      end
      7'b1100111: begin
        k1 = 1'b1; kd = 1'b1;
        islem_ok  = (f3 == 3'd0);
        sonuc_d   = ps_art4;
        yeni_ps_d = {jalr_t[XL-1:1], 1'b0};
      end
      default: islem_ok = 1'b0;
    endcase
    gecerli_d = islem_ok && (!k1 || idx_ok(rs1)) && (!k2 || idx_ok(rs2)) && (!kd || idx_ok(rd));
    yaz_d     = gecerli_d && kd;
    carp_d    = carp_d && gecerli_d;
    if (!gecerli_d) yeni_ps_d = ps_art4;
  end

`ifdef ISLEMCI_CARPMA_EN
  logic [XL-1:0]   carpilan_q, carpan_q, birikim_q, birikim_d;
  logic [SH_W-1:0] sayac_q;
  assign birikim_d = birikim_q + (carpan_q[0] ? carpilan_q : '0);
`endif

  always_ff @(posedge saat or negedge reset_n) begin
    if (!reset_n) begin
      durum_q    <= BEKLE;
      ps_q       <= BASLANGIC_PS;
      regs_q     <= '0;
      buyruk_q   <= '0;
      rd_q       <= '0;
      sonuc_q    <= '0;
      yeni_ps_q  <= '0;
      yaz_q      <= 1'b0;
      hata_q     <= 1'b0;
      hazir_q    <= 1'b1;
      tamam_q    <= 1'b0;
      gecersiz_q <= 1'b0;
`ifdef ISLEMCI_CARPMA_EN
      carpilan_q <= '0;
      carpan_q   <= '0;
      birikim_q  <= '0;
      sayac_q    <= '0;
`endif
    end else begin
      tamam_q <= 1'b0;
      case (durum_q)
        BEKLE: if (bus.buyruk_gecerli && hazir_q) begin
          buyruk_q <= bus.buyruk;
          hazir_q  <= 1'b0;
          durum_q  <= YURUT;
        end
        YURUT: begin
          sonuc_q   <= sonuc_d;
          yaz_q     <= yaz_d;
          yeni_ps_q <= yeni_ps_d;
          hata_q    <= !gecerli_d;
          rd_q      <= rd;
          durum_q   <= YAZ;
`ifdef ISLEMCI_CARPMA_EN
          if (carp_d) begin
            carpilan_q <= a;
            carpan_q   <= b;
            birikim_q  <= '0;
            sayac_q    <= '0;
            durum_q    <= CARP;
          end
`endif
        end
`ifdef ISLEMCI_CARPMA_EN
        CARP: begin
          // one partial product per cycle; the last step feeds the result straight to YAZ
          if (sayac_q == SH_W'(XL-1)) begin
            sonuc_q <= birikim_d;
            durum_q <= YAZ;
          end else begin
            birikim_q  <= birikim_d;
            carpilan_q <= carpilan_q << 1;
            carpan_q   <= carpan_q >> 1;
            sayac_q    <= sayac_q + 1'b1;
          end
        end
`endif
        YAZ: begin
          if (yaz_q && rd_q != 5'd0) regs_q[rd_q[IDX_W-1:0]] <= sonuc_q;
          ps_q    <= yeni_ps_q;
          tamam_q <= 1'b1;
          hazir_q <= 1'b1;
          if (hata_q) gecersiz_q <= 1'b1;
          durum_q <= BEKLE;
        end
        default: durum_q <= BEKLE;
      endcase
    end
  end

  assign bus.buyruk_hazir    = hazir_q;
  assign bus.ps              = ps_q;
  assign bus.yazmac_gozlem   = regs_q[IDX_W'(GOZLEM_YAZMACI)];
  assign bus.tamamlandi      = tamam_q;
  assign bus.gecersiz_buyruk = gecersiz_q;
endmodule

// File: tb/tb_islemci_cok_cevrim.sv
// Table-driven bench for islemci_cok_cevrim with a retire scoreboard; x10 is the observed register.
module tb_islemci_cok_cevrim;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  islemci_cok_cevrim_if #(.VERI_GENISLIGI(32)) bus ();
  islemci_cok_cevrim #(.VERI_GENISLIGI(32), .YAZMAC_SAYISI(32), .BASLANGIC_PS(32'h0), .GOZLEM_YAZMACI(10))
    dut (.saat(clk), .reset_n(rst_n), .bus(bus));

  int errors = 0, checks = 0, pulses = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] ps; logic [31:0] x10; logic ill; int unsigned due; } beklenti_t;
  beklenti_t sb[$];

  typedef struct { bit rst; logic [31:0] ins; logic [31:0] ps; logic [31:0] x10; bit ill; int lat; } vec_t;
  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fI(input int imm, input int rs1, input int f3, input int rd, input logic [6:0] op = 7'h13);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
  endfunction
  function automatic logic [31:0] fR(input int f7, input int rs2, input int rs1, input int f3, input int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
  endfunction
  function automatic logic [31:0] fB(input int imm, input int rs2, input int rs1, input int f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] fJ(input int imm, input int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
  endfunction

  task automatic ekle(input bit r, input logic [31:0] i, input logic [31:0] p, input logic [31:0] x, input bit il, input int lat = 2);
    vt.push_back('{r, i, p, x, il, lat});
  endtask

  // retire monitor: every tamamlandi pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && bus.tamamlandi) begin
      pulses++;
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL retire_unexpected: got retire at ps %h expected none", bus.ps);
      end else begin
        beklenti_t e;
        e = sb.pop_front();
        chk("ps", bus.ps, e.ps);
        chk("x10", bus.yazmac_gozlem, e.x10);
        chk("illegal", {31'b0, bus.gecersiz_buyruk}, {31'b0, e.ill});
        chk("latency", cyc, e.due);
        chk("ready_at_retire", {31'b0, bus.buyruk_hazir}, 32'd1);
      end
    end
  end

  task automatic bosalt();
    for (int n = 0; n < 200 && sb.size() != 0; n++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic sifirla();
    bosalt();
    bus.buyruk_gecerli = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_ps", bus.ps, 32'h0);
    chk("rst_ready", {31'b0, bus.buyruk_hazir}, 32'd1);
    chk("rst_done", {31'b0, bus.tamamlandi}, 32'd0);
    chk("rst_illegal", {31'b0, bus.gecersiz_buyruk}, 32'd0);
    chk("rst_x10", bus.yazmac_gozlem, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic gonder(input logic [31:0] ins, input logic [31:0] eps, input logic [31:0] ex10, input bit eill, input int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.buyruk_hazir && n < 100) begin @(negedge clk); n++; end
    if (!bus.buyruk_hazir) begin
      checks++; errors++;
      $display("FAIL ready_timeout: got ready 0 expected 1");
      return;
    end
    bus.buyruk = ins;
    bus.buyruk_gecerli = 1'b1;
    @(posedge clk);
    #1;
    bus.buyruk_gecerli = 1'b0;
    bus.buyruk = $urandom;
    sb.push_back('{eps, ex10, eill, cyc + lat});
    chk("ready_busy", {31'b0, bus.buyruk_hazir}, 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int p0;
    bus.buyruk = '0;
    bus.buyruk_gecerli = 1'b0;

    // section A: ALU
    ekle(1, 32'h00700513,            32'h04, 32'h7,        0);
    ekle(0, fI(5, 0, 0, 1),          32'h08, 32'h7,        0);
    ekle(0, fR(32'h20, 1, 0, 0, 6),  32'h0C, 32'h7,        0);
    ekle(0, fR(0, 0, 6, 0, 10),      32'h10, 32'hFFFFFFFB, 0);
    ekle(0, fI(32'h401, 6, 5, 8),    32'h14, 32'hFFFFFFFB, 0);
    ekle(0, fR(0, 0, 8, 0, 10),      32'h18, 32'hFFFFFFFD, 0);
    ekle(0, fI(1, 6, 5, 7),          32'h1C, 32'hFFFFFFFD, 0);
    ekle(0, fR(0, 0, 7, 0, 10),      32'h20, 32'h7FFFFFFD, 0);
    ekle(0, fI(3, 1, 1, 10),         32'h24, 32'h28,       0);
    ekle(0, fR(0, 1, 6, 2, 10),      32'h28, 32'h1,        0);
    ekle(0, fR(0, 1, 6, 3, 10),      32'h2C, 32'h0,        0);
    ekle(0, fI(-1, 1, 4, 10),        32'h30, 32'hFFFFFFFA, 0);
    ekle(0, fI(32'hF0, 0, 0, 2),     32'h34, 32'hFFFFFFFA, 0);
    ekle(0, fI(32'h3C, 2, 7, 10),    32'h38, 32'h30,       0);
    ekle(0, fI(32'hF, 2, 6, 10),     32'h3C, 32'hFF,       0);
    ekle(0, fR(0, 2, 1, 6, 10),      32'h40, 32'hF5,       0);
    ekle(0, fR(0, 6, 1, 7, 10),      32'h44, 32'h1,        0);
    ekle(0, fR(0, 6, 1, 4, 10),      32'h48, 32'hFFFFFFFE, 0);
    ekle(0, fR(0, 1, 1, 1, 10),      32'h4C, 32'hA0,       0);
    ekle(0, fR(0, 1, 6, 5, 10),      32'h50, 32'h07FFFFFF, 0);
    ekle(0, fR(32'h20, 1, 6, 5, 10), 32'h54, 32'hFFFFFFFF, 0);
    ekle(0, fI(-4, 6, 2, 10),        32'h58, 32'h1,        0);
    ekle(0, fI(6, 6, 3, 10),         32'h5C, 32'h0,        0);
    ekle(0, fI(6, 6, 0, 10),         32'h60, 32'h1,        0);
    ekle(0, fI(9, 1, 0, 0),          32'h64, 32'h1,        0);
    ekle(0, fR(0, 1, 0, 0, 10),      32'h68, 32'h5,        0);
    ekle(0, fI(7, 0, 0, 12),         32'h6C, 32'h5,        0);
    ekle(0, fI(-3, 0, 0, 11),        32'h70, 32'h5,        0);
    ekle(0, fI(-1, 1, 3, 10),        32'h74, 32'h1,        0);
`ifdef ISLEMCI_CARPMA_EN
    ekle(0, fR(1, 11, 12, 0, 10),    32'h78, 32'hFFFFFFEB, 0, 2 + 32);
`else
    ekle(0, fR(1, 11, 12, 0, 10),    32'h78, 32'h1,        1);
`endif
    // section B: branches and ps wrap
    ekle(1, fI(7, 0, 0, 25),         32'h04, 32'h0,        0);
    ekle(0, fI(7, 0, 0, 26),         32'h08, 32'h0,        0);
    ekle(0, fI(1, 0, 0, 10),         32'h0C, 32'h1,        0);
    ekle(0, fI(1, 10, 0, 10),        32'h10, 32'h2,        0);
    ekle(0, fB(24, 26, 25, 0),       32'h28, 32'h2,        0);
    ekle(0, fB(24, 26, 25, 1),       32'h2C, 32'h2,        0);
    ekle(0, fB(-8, 26, 25, 4),       32'h30, 32'h2,        0);
    ekle(0, fI(-3, 0, 0, 10),        32'h34, 32'hFFFFFFFD, 0);
    ekle(0, fB(16, 26, 10, 4),       32'h44, 32'hFFFFFFFD, 0);
    ekle(0, fB(16, 26, 10, 6),       32'h48, 32'hFFFFFFFD, 0);
    ekle(0, fB(-8, 10, 26, 5),       32'h40, 32'hFFFFFFFD, 0);
    ekle(0, fB(8, 26, 10, 7),        32'h48, 32'hFFFFFFFD, 0);
    ekle(0, fB(8, 26, 10, 5),        32'h4C, 32'hFFFFFFFD, 0);
    ekle(0, fB(-32'h4C, 0, 0, 0),    32'h00, 32'hFFFFFFFD, 0);
    ekle(0, fB(-4, 0, 0, 0),         32'hFFFFFFFC, 32'hFFFFFFFD, 0);
    ekle(0, fJ(8, 10),               32'h04, 32'h0,        0);
    // section C: jumps and illegal encodings
    ekle(1, fI(32'h41, 0, 0, 29),    32'h04, 32'h0,        0);
    ekle(0, 32'h00000013,            32'h08, 32'h0,        0);
    ekle(0, 32'h00000013,            32'h0C, 32'h0,        0);
    ekle(0, 32'h00000013,            32'h10, 32'h0,        0);
    ekle(0, fJ(28, 31),              32'h2C, 32'h0,        0);
    ekle(0, fI(32, 29, 0, 30, 7'h67), 32'h60, 32'h0,       0);
    ekle(0, fR(0, 0, 30, 0, 10),     32'h64, 32'h30,       0);
    ekle(0, fR(0, 0, 31, 0, 10),     32'h68, 32'h14,       0);
    ekle(0, fI(8, 10, 0, 10, 7'h67), 32'h1C, 32'h6C,       0);
    ekle(0, 32'h00000000,            32'h20, 32'h6C,       1);
    ekle(0, fI(3, 0, 0, 10),         32'h24, 32'h3,        1);
    ekle(0, fR(32'h20, 1, 1, 1, 10), 32'h28, 32'h3,        1);
    ekle(0, fB(8, 0, 0, 2),          32'h2C, 32'h3,        1);
    ekle(0, fI(4, 0, 1, 10, 7'h67),  32'h30, 32'h3,        1);

    foreach (vt[i]) begin
      if (vt[i].rst) sifirla();
      gonder(vt[i].ins, vt[i].ps, vt[i].x10, vt[i].ill, vt[i].lat);
    end

    // valid held high through YURUT/YAZ, buyruk changed after acceptance: one retire, latched word
    sifirla();
    p0 = pulses;
    @(negedge clk);
    bus.buyruk = fI(32'h55, 0, 0, 10);
    bus.buyruk_gecerli = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back('{32'h4, 32'h55, 1'b0, cyc + 2});
    bus.buyruk = fI(32'h66, 0, 0, 10);
    repeat (2) @(posedge clk);
    #1;
    bus.buyruk_gecerli = 1'b0;
    repeat (6) @(negedge clk);
    chk("held_valid_pulses", 32'(pulses - p0), 32'd1);
    chk("held_valid_x10", bus.yazmac_gozlem, 32'h55);
    chk("held_valid_ps", bus.ps, 32'h4);

    // reset asserted in YURUT drops the in-flight instruction
    bosalt();
    @(negedge clk);
    bus.buyruk = fI(32'h77, 0, 0, 10);
    bus.buyruk_gecerli = 1'b1;
    @(posedge clk);
    #1;
    bus.buyruk_gecerli = 1'b0;
    p0 = pulses;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_ps", bus.ps, 32'h0);
    chk("midrst_ready", {31'b0, bus.buyruk_hazir}, 32'd1);
    chk("midrst_done", {31'b0, bus.tamamlandi}, 32'd0);
    chk("midrst_x10", bus.yazmac_gozlem, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("midrst_no_retire", 32'(pulses - p0), 32'd0);
    chk("midrst_x10_after", bus.yazmac_gozlem, 32'h0);
    chk("midrst_ps_after", bus.ps, 32'h0);
    gonder(fI(9, 0, 0, 10), 32'h4, 32'h9, 0, 2);
    bosalt();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
